// File: rtl/mux2_arbiter_pkg.sv
// rtl/mux2_arbiter_pkg.sv - shared types and grant encoding for mux2_arbiter
package mux2_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RTZ  = 2'd2
  } state_t;

  localparam logic GRANT_IN1 = 1'b0;
  localparam logic GRANT_IN2 = 1'b1;

endpackage

// File: rtl/mux2_arbiter_rr_pick2.sv
// rtl/mux2_arbiter_rr_pick2.sv - combinational two-way round-robin pick
module rr_pick2
  import mux2_arbiter_pkg::*;
(
  input  logic req1,
  input  logic req2,
  input  logic last,
  output logic valid,
  output logic pick
);

  assign valid = req1 | req2;

  // On a tie the producer not served last wins; otherwise the sole requester.
  always_comb begin
    if (req1 && req2)
      pick = ~last;
    else if (req2)
      pick = GRANT_IN2;
    else
      pick = GRANT_IN1;
  end

endmodule

// File: rtl/mux2_arbiter.sv
// rtl/mux2_arbiter.sv - handshaked round-robin two-input mux with registered output
module mux2_arbiter
  import mux2_arbiter_pkg::*;
#(
  parameter int               Width        = 32,
  parameter logic [Width-1:0] defaultValue = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req1,
  input  logic [Width-1:0] in1,
  output logic             ack1,
  input  logic             req2,
  input  logic [Width-1:0] in2,
  output logic             ack2,
  output logic [Width-1:0] out,
  output logic             out_req,
  input  logic             out_ack,
  output logic             grant
);

  state_t           state, state_n;
  logic [Width-1:0] out_n;
  logic             grant_n, last, last_n;
  logic             ack1_n, ack2_n, out_req_n;
  logic             pick_valid, pick;
  logic             req_g;

  rr_pick2 u_pick (
    .req1  (req1),
    .req2  (req2),
    .last  (last),
    .valid (pick_valid),
    .pick  (pick)
  );

  assign req_g = (grant == GRANT_IN2) ? req2 : req1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      out     <= defaultValue;
      grant   <= GRANT_IN1;
      last    <= GRANT_IN2;
      ack1    <= 1'b0;
      ack2    <= 1'b0;
      out_req <= 1'b0;
    end else begin
      state   <= state_n;
      out     <= out_n;
      grant   <= grant_n;
      last    <= last_n;
      ack1    <= ack1_n;
      ack2    <= ack2_n;
      out_req <= out_req_n;
    end
  end

  always_comb begin
    state_n   = state;
    out_n     = out;
    grant_n   = grant;
    last_n    = last;
    ack1_n    = ack1;
    ack2_n    = ack2;
    out_req_n = out_req;
    case (state)
      IDLE: begin
        // A consumer still holding ack from a previous cycle blocks arbitration.
        if (!out_ack && pick_valid) begin
          out_n     = (pick == GRANT_IN2) ? in2 : in1;
          grant_n   = pick;
          out_req_n = 1'b1;
          state_n   = SEND;
        end
      end
      SEND: begin
        if (out_ack) begin
          out_req_n = 1'b0;
          if (grant == GRANT_IN2)
            ack2_n = 1'b1;
          else
            ack1_n = 1'b1;
          state_n = RTZ;
        end
      end
      RTZ: begin
        if (!req_g && !out_ack) begin
          ack1_n  = 1'b0;
          ack2_n  = 1'b0;
          last_n  = grant;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mux2_arbiter.sv
// tb/tb_mux2_arbiter.sv - directed scoreboard bench for mux2_arbiter
module tb_mux2_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req1, req2, ack1, ack2;
  logic [7:0] in1, in2, out;
  logic       out_req, out_ack, grant;

  typedef struct packed {
    logic       g;
    logic [7:0] d;
  } exp_t;

  exp_t sbq[$];
  logic m_last;
  int   total = 0;
  int   bad   = 0;

  mux2_arbiter #(.Width(8), .defaultValue(8'h5A)) dut (
    .clk     (clk),
    .rst     (rst),
    .req1    (req1),
    .in1     (in1),
    .ack1    (ack1),
    .req2    (req2),
    .in2     (in2),
    .ack2    (ack2),
    .out     (out),
    .out_req (out_req),
    .out_ack (out_ack),
    .grant   (grant)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return out_req;
      1:       return ack1;
      default: return ack2;
    endcase
  endfunction

  task automatic wait_for(input int sel, input logic val, input string tag);
    for (int i = 0; i < 50 && sig(sel) !== val; i++) tick();
    check(tag, {31'b0, sig(sel)}, {31'b0, val});
  endtask

  task automatic push(input logic g, input logic [7:0] d);
    exp_t e;
    e.g = g;
    e.d = d;
    sbq.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1; req1 = 1'b0; req2 = 1'b0; out_ack = 1'b0;
    in1 = 8'h00; in2 = 8'h00;
    tick();
    tick();
    check("reset_out", {24'b0, out}, 32'h5A);
    check("reset_ctl", {28'b0, out_req, ack1, ack2, grant}, 32'h0);
    rst = 1'b0;
    m_last = 1'b1;
    sbq.delete();
    tick();
  endtask

  // Consumer side: take the word, ack after dly cycles, then producer returns to zero.
  task automatic serve(input int dly, input string tag);
    exp_t e;
    e = '0;
    wait_for(0, 1'b1, {tag, "_oreq"});
    check({tag, "_sbq"}, {31'b0, sbq.size() != 0}, 32'h1);
    if (sbq.size() != 0) e = sbq.pop_front();
    check({tag, "_out"}, {24'b0, out}, {24'b0, e.d});
    check({tag, "_grant"}, {31'b0, grant}, {31'b0, e.g});
    repeat (dly) begin
      tick();
      check({tag, "_hold"}, {29'b0, out_req, ack1, ack2}, 32'h4);
    end
    out_ack = 1'b1;
    tick();
    check({tag, "_ack"}, {29'b0, out_req, ack1, ack2}, {29'b0, 1'b0, ~e.g, e.g});
    if (e.g) req2 = 1'b0;
    else     req1 = 1'b0;
    out_ack = 1'b0;
    tick();
    check({tag, "_rtz"}, {29'b0, out_req, ack1, ack2}, 32'h0);
    m_last = e.g;
  endtask

  initial begin
    logic w;
    rst = 1'b1; req1 = 1'b0; req2 = 1'b0; out_ack = 1'b0;
    in1 = 8'h00; in2 = 8'h00;
    #1;
    check("async_reset", {24'b0, out}, 32'h5A);
    do_reset();

    // Single producer with one-edge request latency
    req1 = 1'b1; in1 = 8'hA5;
    push(1'b0, 8'hA5);
    tick();
    check("single_latency", {31'b0, out_req}, 32'h1);
    serve(2, "single");

    // Six ties in a row from reset alternate strictly
    do_reset();
    req1 = 1'b1; req2 = 1'b1; in1 = 8'h11; in2 = 8'h22;
    for (int i = 0; i < 6; i++) begin
      w = ~m_last;
      push(w, w ? 8'h22 : 8'h11);
      serve(1, "tie");
      if (i < 5) begin
        if (w) req2 = 1'b1;
        else   req1 = 1'b1;
      end else begin
        req1 = 1'b0;
        req2 = 1'b0;
      end
    end
    tick();

    // Late losing request stays pending through producer 1's transfer
    req1 = 1'b1; in1 = 8'h11;
    push(1'b0, 8'h11);
    tick();
    req2 = 1'b1; in2 = 8'h22;
    push(1'b1, 8'h22);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("late_pending", {21'b0, ack2, out_req, out}, {21'b0, 1'b0, 1'b1, 8'h11});
    end
    serve(0, "late_first");
    check("late_out_hold", {24'b0, out}, 32'h11);
    serve(1, "late_second");

    // Consumer stall
    req1 = 1'b1; in1 = 8'h33;
    push(1'b0, 8'h33);
    wait_for(0, 1'b1, "stall_oreq");
    for (int i = 0; i < 20; i++) begin
      tick();
      check("stall", {21'b0, out_req, ack1, ack2, out}, {21'b0, 3'b100, 8'h33});
    end
    serve(0, "stall_end");

    // Reset while ack2 is high in RTZ
    req2 = 1'b1; in2 = 8'h44;
    wait_for(0, 1'b1, "rst_oreq");
    check("rst_win", {23'b0, grant, out}, {23'b0, 1'b1, 8'h44});
    out_ack = 1'b1;
    tick();
    check("rst_ack2", {31'b0, ack2}, 32'h1);
    rst = 1'b1;
    #1;
    check("rst_mid_ctl", {28'b0, out_req, ack1, ack2, grant}, 32'h0);
    check("rst_mid_out", {24'b0, out}, 32'h5A);
    req2 = 1'b0; out_ack = 1'b0;
    tick();
    rst = 1'b0;
    m_last = 1'b1;
    tick();
    req1 = 1'b1; req2 = 1'b1; in1 = 8'h11; in2 = 8'h22;
    push(1'b0, 8'h11);
    serve(1, "rst_tie");
    push(1'b1, 8'h22);
    serve(0, "rst_tie2");

    // req1 dropped during SEND still completes with an ack pulse
    req1 = 1'b1; in1 = 8'h66;
    push(1'b0, 8'h66);
    wait_for(0, 1'b1, "viol1_oreq");
    req1 = 1'b0;
    tick();
    check("viol1_hold", {22'b0, out_req, ack1, out}, {22'b0, 2'b10, 8'h66});
    serve(1, "viol1");

    // out_ack stuck high in IDLE blocks arbitration
    out_ack = 1'b1;
    req2 = 1'b1; in2 = 8'h77;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("viol2_block", {31'b0, out_req}, 32'h0);
    end
    out_ack = 1'b0;
    push(1'b1, 8'h77);
    serve(0, "viol2");

    check("sb_empty", sbq.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
